iz_param_loader_multi: RTL and testbench

- Serial parameter loader for an array of N_CH Izhikevich neurons; next generation of the single-neuron serial loader.
- A framed 1-bit stream carries a channel index, four raw signed parameters (a, b, c, d) of PARAM_W bits and an 8-bit checksum.
- Parameters are loaded into a shadow bank and committed to that channel's active bank in one cycle, only if the checksum matches. Active outputs are never disturbed by a partial or corrupted frame.

---
 rtl/iz_param_loader_multi.sv | 217 +++++++++++++++++++++
 tb/tb_iz_param_loader_multi.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/iz_param_loader_multi.sv
// Serial parameter loader for an array of Izhikevich neuron channels.
// A framed 1-bit stream (channel, a, b, c, d, checksum) fills a shadow bank
// that is committed to the addressed channel's active bank only when the
// checksum matches and the channel exists.
module iz_param_loader_multi #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned CH_W      = 2,
  parameter int unsigned PARAM_W   = 16,
  parameter int          DEFAULT_A = 1,
  parameter int          DEFAULT_B = 13,
  parameter int          DEFAULT_C = -4160,
  parameter int          DEFAULT_D = 128
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      load_enable,
  input  logic                      serial_data_in,
  output logic [N_CH*PARAM_W-1:0]   param_a_flat,
  output logic [N_CH*PARAM_W-1:0]   param_b_flat,
  output logic [N_CH*PARAM_W-1:0]   param_c_flat,
  output logic [N_CH*PARAM_W-1:0]   param_d_flat,
  output logic [N_CH-1:0]           update_pulse,
  output logic                      frame_done,
  output logic                      frame_error,
  output logic                      busy
);

  localparam int unsigned CSUM_W     = 8;
  localparam int unsigned NUM_FIELDS = 4;
  localparam int unsigned CNT_MAX    = (PARAM_W > CSUM_W) ?
                                       ((PARAM_W > CH_W) ? PARAM_W : CH_W) :
                                       ((CSUM_W > CH_W) ? CSUM_W : CH_W);
  localparam int unsigned CNT_W      = $clog2(CNT_MAX);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAY, S_CHK, S_COMMIT} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [1:0]           field_q, field_d;
  logic [CSUM_W-1:0]    csum_q, csum_d;
  logic [CSUM_W-1:0]    rx_csum_q, rx_csum_d;
  logic [CH_W-1:0]      sh_ch_q, sh_ch_d;
  logic [PARAM_W-1:0]   sh_q [NUM_FIELDS];
  logic [PARAM_W-1:0]   sh_d [NUM_FIELDS];
  logic [PARAM_W-1:0]   act_q [N_CH][NUM_FIELDS];
  logic [PARAM_W-1:0]   act_d [N_CH][NUM_FIELDS];
  logic                 le_prev_q;
  logic [N_CH-1:0]      upd_q, upd_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;

  logic                 rise;
  logic                 abort;
  logic                 ch_ok;
  logic [CSUM_W-1:0]    csum_shift;

  assign rise       = load_enable & ~le_prev_q;
  assign csum_shift = {csum_q[CSUM_W-2:0], csum_q[CSUM_W-1] ^ serial_data_in};
  assign ch_ok      = ({1'b0, sh_ch_q} < (CH_W+1)'(N_CH));

  // Next-state, datapath and pulse computation
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    field_d   = field_q;
    csum_d    = csum_q;
    rx_csum_d = rx_csum_q;
    sh_ch_d   = sh_ch_q;
    sh_d      = sh_q;
    act_d     = act_q;
    upd_d     = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    abort     = 1'b0;

    if (enable) begin
      unique case (state_q)
        S_IDLE: begin
          if (rise) begin
            state_d   = S_HDR;
            bit_cnt_d = '0;
            field_d   = '0;
            csum_d    = '0;
            rx_csum_d = '0;
            sh_ch_d   = '0;
            for (int f = 0; f < NUM_FIELDS; f++) sh_d[f] = '0;
          end
        end
        S_HDR: begin
          if (!load_enable) begin
            abort = 1'b1;
          end else begin
            sh_ch_d = CH_W'({sh_ch_q, serial_data_in});
            csum_d  = csum_shift;
            if (bit_cnt_q == CNT_W'(CH_W - 1)) begin
              bit_cnt_d = '0;
              state_d   = S_PAY;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        S_PAY: begin
          if (!load_enable) begin
            abort = 1'b1;
          end else begin
            sh_d[field_q] = PARAM_W'({sh_q[field_q], serial_data_in});
            csum_d        = csum_shift;
            if (bit_cnt_q == CNT_W'(PARAM_W - 1)) begin
              bit_cnt_d = '0;
              if (field_q == 2'd3) state_d = S_CHK;
              else                 field_d = field_q + 2'd1;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        S_CHK: begin
          if (!load_enable) begin
            abort = 1'b1;
          end else begin
            rx_csum_d = {rx_csum_q[CSUM_W-2:0], serial_data_in};
            if (bit_cnt_q == CNT_W'(CSUM_W - 1)) begin
              bit_cnt_d = '0;
              state_d   = S_COMMIT;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        S_COMMIT: begin
          state_d = S_IDLE;
          if ((rx_csum_q == csum_q) && ch_ok) begin
            for (int k = 0; k < N_CH; k++) begin
              if (CH_W'(k) == sh_ch_q) begin
                act_d[k] = sh_q;
                upd_d[k] = 1'b1;
              end
            end
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Dropped frame gate: discard the partial frame and flag it
      if (abort) begin
        state_d   = S_IDLE;
        err_d     = 1'b1;
        bit_cnt_d = '0;
        field_d   = '0;
        csum_d    = '0;
        rx_csum_d = '0;
        sh_ch_d   = '0;
        for (int f = 0; f < NUM_FIELDS; f++) sh_d[f] = '0;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      field_q   <= '0;
      csum_q    <= '0;
      rx_csum_q <= '0;
      sh_ch_q   <= '0;
      for (int f = 0; f < NUM_FIELDS; f++) sh_q[f] <= '0;
      for (int k = 0; k < N_CH; k++) begin
        act_q[k][0] <= PARAM_W'(DEFAULT_A);
        act_q[k][1] <= PARAM_W'(DEFAULT_B);
        act_q[k][2] <= PARAM_W'(DEFAULT_C);
        act_q[k][3] <= PARAM_W'(DEFAULT_D);
      end
      le_prev_q <= 1'b0;
      upd_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      field_q   <= field_d;
      csum_q    <= csum_d;
      rx_csum_q <= rx_csum_d;
      sh_ch_q   <= sh_ch_d;
      sh_q      <= sh_d;
      act_q     <= act_d;
      le_prev_q <= load_enable;
      upd_q     <= upd_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  // Flatten the active banks onto the output buses
  for (genvar k = 0; k < N_CH; k++) begin : g_flat
    assign param_a_flat[k*PARAM_W +: PARAM_W] = act_q[k][0];
    assign param_b_flat[k*PARAM_W +: PARAM_W] = act_q[k][1];
    assign param_c_flat[k*PARAM_W +: PARAM_W] = act_q[k][2];
    assign param_d_flat[k*PARAM_W +: PARAM_W] = act_q[k][3];
  end

  assign update_pulse = upd_q;
  assign frame_done   = done_q;
  assign frame_error  = err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_iz_param_loader_multi.sv
// Directed, table-driven bench for iz_param_loader_multi: a 4-channel and a
// 3-channel instance share one serial stream and are checked against a model.
module tb_iz_param_loader_multi;

  localparam int CH_W    = 2;
  localparam int PW      = 16;
  localparam int FRAME_N = CH_W + 4*PW + 8;

  logic clk = 1'b0;
  logic reset, enable, load_enable, sdi;

  logic [4*PW-1:0] a4, b4, c4, d4;
  logic [3:0]      upd4;
  logic            done4, err4, busy4;
  logic [3*PW-1:0] a3, b3, c3, d3;
  logic [2:0]      upd3;
  logic            done3, err3, busy3;

  always #5 clk = ~clk;

  iz_param_loader_multi dut (
    .clk(clk), .reset(reset), .enable(enable), .load_enable(load_enable),
    .serial_data_in(sdi),
    .param_a_flat(a4), .param_b_flat(b4), .param_c_flat(c4), .param_d_flat(d4),
    .update_pulse(upd4), .frame_done(done4), .frame_error(err4), .busy(busy4)
  );

  iz_param_loader_multi #(.N_CH(3)) dut3 (
    .clk(clk), .reset(reset), .enable(enable), .load_enable(load_enable),
    .serial_data_in(sdi),
    .param_a_flat(a3), .param_b_flat(b3), .param_c_flat(c3), .param_d_flat(d3),
    .update_pulse(upd3), .frame_done(done3), .frame_error(err3), .busy(busy3)
  );

  typedef struct {
    int          ch;
    logic [15:0] a, b, c, d;
    bit          corrupt;
    bit          keep_high;
    logic [3:0]  exp_upd4;
    logic [2:0]  exp_upd3;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [15:0] m4 [4][4];
  logic [15:0] m3 [3][4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [FRAME_N-1:0] build(input vec_t v);
    logic [CH_W+4*PW-1:0] body;
    logic [7:0] cs;
    body = {2'(v.ch), v.a, v.b, v.c, v.d};
    cs = 8'h00;
    for (int i = CH_W+4*PW-1; i >= 0; i--) cs = {cs[6:0], cs[7] ^ body[i]};
    if (v.corrupt) cs[0] = ~cs[0];
    return {body, cs};
  endfunction

  function automatic logic [63:0] pack4(input int f);
    logic [63:0] r;
    for (int k = 0; k < 4; k++) r[k*PW +: PW] = m4[k][f];
    return r;
  endfunction

  function automatic logic [47:0] pack3(input int f);
    logic [47:0] r;
    for (int k = 0; k < 3; k++) r[k*PW +: PW] = m3[k][f];
    return r;
  endfunction

  task automatic check_banks(input string tag);
    chk({tag, " a4"}, a4, pack4(0));
    chk({tag, " b4"}, b4, pack4(1));
    chk({tag, " c4"}, c4, pack4(2));
    chk({tag, " d4"}, d4, pack4(3));
    chk({tag, " a3"}, 64'(a3), 64'(pack3(0)));
    chk({tag, " b3"}, 64'(b3), 64'(pack3(1)));
    chk({tag, " c3"}, 64'(c3), 64'(pack3(2)));
    chk({tag, " d3"}, 64'(d3), 64'(pack3(3)));
  endtask

  // Drives one frame; stall_at/abort_at are bit indices (-1 = none)
  task automatic run_frame(input string tag, input vec_t v, input int stall_at, input int abort_at);
    logic [FRAME_N-1:0] bits;
    bits = build(v);
    @(negedge clk);
    load_enable = 1'b1; enable = 1'b1; sdi = 1'($urandom);
    for (int i = 0; i < FRAME_N; i++) begin
      @(negedge clk);
      if (i == 10) chk({tag, " busy mid-frame"}, 64'(busy4), 64'd1);
      if (i == stall_at) begin
        enable = 1'b0;
        repeat (5) begin
          sdi = 1'($urandom);
          @(negedge clk);
        end
        chk({tag, " busy in stall"}, 64'(busy4), 64'd1);
        enable = 1'b1;
      end
      if (i == abort_at) begin
        load_enable = 1'b0; sdi = 1'b0;
        @(negedge clk);
        chk({tag, " abort err4"}, 64'(err4), 64'd1);
        chk({tag, " abort err3"}, 64'(err3), 64'd1);
        chk({tag, " abort done4"}, 64'(done4), 64'd0);
        chk({tag, " abort upd4"}, 64'(upd4), 64'd0);
        chk({tag, " abort busy"}, 64'(busy4), 64'd0);
        @(negedge clk);
        chk({tag, " abort err4 width"}, 64'(err4), 64'd0);
        return;
      end
      sdi = bits[FRAME_N-1-i];
    end
    @(negedge clk);
    chk({tag, " early done4"}, 64'(done4), 64'd0);
    chk({tag, " early err4"}, 64'(err4), 64'd0);
    chk({tag, " busy commit"}, 64'(busy4), 64'd1);
    if (!v.keep_high) load_enable = 1'b0;
    sdi = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      if (v.exp_upd4[k]) begin m4[k][0] = v.a; m4[k][1] = v.b; m4[k][2] = v.c; m4[k][3] = v.d; end
    for (int k = 0; k < 3; k++)
      if (v.exp_upd3[k]) begin m3[k][0] = v.a; m3[k][1] = v.b; m3[k][2] = v.c; m3[k][3] = v.d; end
    chk({tag, " upd4"}, 64'(upd4), 64'(v.exp_upd4));
    chk({tag, " done4"}, 64'(done4), 64'(|v.exp_upd4));
    chk({tag, " err4"}, 64'(err4), 64'(~|v.exp_upd4));
    chk({tag, " upd3"}, 64'(upd3), 64'(v.exp_upd3));
    chk({tag, " done3"}, 64'(done3), 64'(|v.exp_upd3));
    chk({tag, " err3"}, 64'(err3), 64'(~|v.exp_upd3));
    chk({tag, " busy after"}, 64'(busy4), 64'd0);
    check_banks(tag);
    @(negedge clk);
    chk({tag, " pulses cleared 4"}, 64'({upd4, done4, err4}), 64'd0);
    chk({tag, " pulses cleared 3"}, 64'({upd3, done3, err3}), 64'd0);
    if (v.keep_high) begin
      repeat (3) @(negedge clk);
      chk({tag, " no restart"}, 64'(busy4), 64'd0);
      load_enable = 1'b0;
    end
  endtask

  vec_t vecs [4];
  vec_t v_abort, v_ch1, v_stall;

  initial begin
    vecs[0] = '{2, 16'h0002, 16'hFFF3, 16'hEF80, 16'h0100, 1'b0, 1'b0, 4'b0100, 3'b100};
    vecs[1] = '{2, 16'h0002, 16'hFFF3, 16'hEF80, 16'h0100, 1'b1, 1'b0, 4'b0000, 3'b000};
    vecs[2] = '{0, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 4'b0001, 3'b001};
    vecs[3] = '{3, 16'h1234, 16'hABCD, 16'h5555, 16'hAAAA, 1'b0, 1'b1, 4'b1000, 3'b000};
    v_abort = '{1, 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 1'b0, 1'b0, 4'b0000, 3'b000};
    v_ch1   = '{1, 16'h0014, 16'h0033, 16'hFF00, 16'h0008, 1'b0, 1'b0, 4'b0010, 3'b010};
    v_stall = '{1, 16'h0A0A, 16'hF0F0, 16'h8001, 16'h7FFE, 1'b0, 1'b0, 4'b0010, 3'b010};

    reset = 1'b0; enable = 1'b0; load_enable = 1'b0; sdi = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m4[k][0] = 16'h0001; m4[k][1] = 16'h000D; m4[k][2] = 16'hEFC0; m4[k][3] = 16'h0080;
    end
    for (int k = 0; k < 3; k++) begin
      m3[k][0] = 16'h0001; m3[k][1] = 16'h000D; m3[k][2] = 16'hEFC0; m3[k][3] = 16'h0080;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_banks("reset");
    chk("reset pulses4", 64'({upd4, done4, err4}), 64'd0);
    chk("reset busy4", 64'(busy4), 64'd0);
    chk("reset busy3", 64'(busy3), 64'd0);

    // Rise while enable is low is lost
    load_enable = 1'b1;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("lost rise busy", 64'(busy4), 64'd0);
    load_enable = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_frame($sformatf("vec%0d", i), vecs[i], -1, -1);

    run_frame("abort", v_abort, -1, CH_W + 30);
    check_banks("post-abort");
    run_frame("after-abort ch1", v_ch1, -1, -1);
    run_frame("stall ch1", v_stall, 40, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
